// File: rtl/poly_voice_allocator_pkg.sv
// Shared types and constants for the polyphonic voice allocator and its voice slots.
package synth_voice_pkg;

  typedef enum logic [1:0] {
    EV_OFF    = 2'd0,
    EV_ON     = 2'd1,
    EV_SUS    = 2'd2,
    EV_ALLOFF = 2'd3
  } ev_type_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } alloc_state_t;

  localparam int SUSTAIN_THRESH = 64;
  localparam int AGE_W = 8;
  localparam logic [AGE_W-1:0] AGE_MAX = 8'd255;

endpackage

// File: rtl/poly_voice_allocator_if.sv
// Decoded MIDI event handshake from the status/sequencer decode into the allocator.
interface poly_voice_allocator_if #(
  parameter int C_WIDTH = 2
);
  import synth_voice_pkg::*;

  logic               ev_valid;
  logic               ev_ready;
  ev_type_t           ev_type;
  logic [C_WIDTH-1:0] ev_ch;
  logic [6:0]         ev_key;
  logic [6:0]         ev_val;

  modport master (output ev_valid, ev_type, ev_ch, ev_key, ev_val, input ev_ready);
  modport slave  (input ev_valid, ev_type, ev_ch, ev_key, ev_val, output ev_ready);

endinterface

// File: rtl/poly_voice_allocator_voice_slot.sv
// Per-voice storage (key, channel, held flag, age) plus the compare terms the scan uses.
module voice_slot
  import synth_voice_pkg::*;
#(
  parameter int C_WIDTH = 2
) (
  input  logic               reg_clk,
  input  logic               reset_reg_N,
  input  logic               gate,
  input  logic               free,
  input  logic [6:0]         cmp_key,
  input  logic [C_WIDTH-1:0] cmp_ch,
  input  logic               load,
  input  logic               age_inc,
  input  logic               set_held,
  input  logic               clr_held,
  output logic               match,
  output logic               ch_match,
  output logic               available,
  output logic               held,
  output logic [AGE_W-1:0]   age,
  output logic [6:0]         key
);

  logic [C_WIDTH-1:0] ch;

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      key  <= '0;
      ch   <= '0;
      held <= 1'b0;
      age  <= '0;
    end else if (load) begin
      key  <= cmp_key;
      ch   <= cmp_ch;
      held <= 1'b0;
      age  <= '0;
    end else begin
      if (age_inc && age != AGE_MAX) age <= age + 1'b1;
      if (set_held)      held <= 1'b1;
      else if (clr_held) held <= 1'b0;
    end
  end

  assign ch_match  = (ch == cmp_ch);
  assign match     = gate && ch_match && (key == cmp_key);
  assign available = !gate && !held && free;

endmodule

// File: rtl/poly_voice_allocator.sv
// Multi-channel voice allocator: scans every voice once per event, then commits note-on choices.
//   state  | meaning
//   IDLE   | ev_ready high, waiting for an event
//   SCAN   | visit voice idx, apply releases, collect note-on candidates
//   COMMIT | apply note-on selection / drop, update sustain flags
module poly_voice_allocator
  import synth_voice_pkg::*;
#(
  parameter int VOICES   = 16,
  parameter int V_WIDTH  = 4,
  parameter int CHANNELS = 4,
  parameter int C_WIDTH  = 2
) (
  input  logic                   reg_clk,
  input  logic                   reset_reg_N,
  poly_voice_allocator_if.slave  ev,
  input  logic                   steal_en,
  input  logic [VOICES-1:0]      voice_free,
  output logic [VOICES-1:0]      keys_on,
  output logic                   note_on,
  output logic [V_WIDTH-1:0]     cur_key_adr,
  output logic [7:0]             cur_key_val,
  output logic [7:0]             cur_vel_on,
  output logic [7:0]             cur_vel_off,
  output logic [C_WIDTH-1:0]     cur_ch,
  output logic                   note_stolen,
  output logic                   dropped,
  output logic [V_WIDTH:0]       active_keys
);

  alloc_state_t state, state_nxt;
  logic [V_WIDTH-1:0] idx;
  ev_type_t           l_type;
  logic [C_WIDTH-1:0] l_ch;
  logic [6:0]         l_key, l_val;
  logic               l_ok, ch_ok;
  logic               off_done, ret_hit, av_hit;
  logic [V_WIDTH-1:0] ret_idx, av_idx, old_idx;
  logic [AGE_W-1:0]   old_age;
  logic [CHANNELS-1:0] sus;

  logic [VOICES-1:0] s_match, s_chm, s_avail, s_held;
  logic [AGE_W-1:0]  s_age [VOICES];
  logic [6:0]        s_key [VOICES];
  logic [VOICES-1:0] load_v, inc_v, set_held_v, clr_held_v;
  logic              scan_rel, scan_hold, sel_hit, sel_steal;
  logic [V_WIDTH-1:0] sel_idx;

  generate
    if (CHANNELS >= (1 << C_WIDTH)) begin : g_ch_full
      assign ch_ok = 1'b1;
    end else begin : g_ch_part
      assign ch_ok = int'(ev.ev_ch) < CHANNELS;
    end
  endgenerate

  for (genvar v = 0; v < VOICES; v++) begin : g_slot
    voice_slot #(.C_WIDTH(C_WIDTH)) u_slot (
      .reg_clk    (reg_clk),
      .reset_reg_N(reset_reg_N),
      .gate       (keys_on[v]),
      .free       (voice_free[v]),
      .cmp_key    (l_key),
      .cmp_ch     (l_ch),
      .load       (load_v[v]),
      .age_inc    (inc_v[v]),
      .set_held   (set_held_v[v]),
      .clr_held   (clr_held_v[v]),
      .match      (s_match[v]),
      .ch_match   (s_chm[v]),
      .available  (s_avail[v]),
      .held       (s_held[v]),
      .age        (s_age[v]),
      .key        (s_key[v])
    );
  end

  assign ev.ev_ready  = (state == IDLE);
  assign active_keys  = (V_WIDTH+1)'($countones(keys_on));

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    scan_rel   = 1'b0;
    scan_hold  = 1'b0;
    sel_hit    = 1'b0;
    sel_steal  = 1'b0;
    sel_idx    = '0;
    load_v     = '0;
    inc_v      = '0;
    set_held_v = '0;
    clr_held_v = '0;
    case (state)
      IDLE: if (ev.ev_valid) state_nxt = SCAN;
      SCAN: begin
        if (l_ok) begin
          case (l_type)
            EV_OFF: if (!off_done && s_match[idx] && !s_held[idx]) begin
              if (sus[l_ch]) scan_hold = 1'b1;
              else           scan_rel  = 1'b1;
            end
            EV_SUS:    if (l_val < 7'(SUSTAIN_THRESH) && s_chm[idx] && s_held[idx]) scan_rel = 1'b1;
            EV_ALLOFF: if (s_chm[idx] && keys_on[idx]) scan_rel = 1'b1;
            default: ;
          endcase
        end
        if (idx == V_WIDTH'(VOICES-1)) state_nxt = COMMIT;
      end
      COMMIT: begin
        state_nxt = IDLE;
        if (l_ok && l_type == EV_ON) begin
          if (ret_hit) begin
            sel_hit = 1'b1;
            sel_idx = ret_idx;
          end else if (av_hit) begin
            sel_hit = 1'b1;
            sel_idx = av_idx;
          end else if (steal_en) begin
            sel_hit   = 1'b1;
            sel_steal = 1'b1;
            sel_idx   = old_idx;
          end
          if (sel_hit) begin
            load_v[sel_idx] = 1'b1;
            inc_v = keys_on & ~load_v;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (scan_rel)  clr_held_v[idx] = 1'b1;
    if (scan_hold) set_held_v[idx] = 1'b1;
  end

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      idx <= '0; l_type <= EV_OFF; l_ch <= '0; l_key <= '0; l_val <= '0; l_ok <= 1'b0;
      off_done <= 1'b0; ret_hit <= 1'b0; av_hit <= 1'b0;
      ret_idx <= '0; av_idx <= '0; old_idx <= '0; old_age <= '0;
      sus <= '0; keys_on <= '0;
      note_on <= 1'b0; note_stolen <= 1'b0; dropped <= 1'b0;
      cur_key_adr <= '0; cur_key_val <= '0; cur_vel_on <= '0; cur_vel_off <= '0; cur_ch <= '0;
    end else begin
      note_on     <= 1'b0;
      note_stolen <= 1'b0;
      dropped     <= 1'b0;
      case (state)
        IDLE: if (ev.ev_valid) begin
          // A zero-velocity note-on is folded into a note-off here so the scan sees one type.
          l_type   <= (ev.ev_type == EV_ON && ev.ev_val == 7'd0) ? EV_OFF : ev.ev_type;
          l_ch     <= ev.ev_ch;
          l_key    <= ev.ev_key;
          l_val    <= ev.ev_val;
          l_ok     <= ch_ok;
          idx      <= '0;
          off_done <= 1'b0;
          ret_hit  <= 1'b0;
          av_hit   <= 1'b0;
          old_idx  <= '0;
          old_age  <= '0;
        end
        SCAN: begin
          idx <= idx + 1'b1;
          if (!ret_hit && s_match[idx]) begin
            ret_hit <= 1'b1;
            ret_idx <= idx;
          end
          if (!av_hit && s_avail[idx]) begin
            av_hit <= 1'b1;
            av_idx <= idx;
          end
          if (s_age[idx] > old_age) begin
            old_age <= s_age[idx];
            old_idx <= idx;
          end
          if (scan_rel || scan_hold) off_done <= 1'b1;
          if (scan_rel) begin
            keys_on[idx] <= 1'b0;
            note_on      <= 1'b1;
            cur_key_adr  <= idx;
            cur_key_val  <= {1'b0, s_key[idx]};
            cur_vel_on   <= '0;
            cur_vel_off  <= (l_type == EV_OFF) ? {1'b0, l_val} : 8'd0;
            cur_ch       <= l_ch;
          end
        end
        COMMIT: begin
          if (l_ok && l_type == EV_SUS)    sus[l_ch] <= (l_val >= 7'(SUSTAIN_THRESH));
          if (l_ok && l_type == EV_ALLOFF) sus[l_ch] <= 1'b0;
          if (sel_hit) begin
            keys_on[sel_idx] <= 1'b1;
            note_on          <= 1'b1;
            note_stolen      <= sel_steal;
            cur_key_adr      <= sel_idx;
            cur_key_val      <= {1'b0, l_key};
            cur_vel_on       <= {1'b0, l_val};
            cur_vel_off      <= '0;
            cur_ch           <= l_ch;
          end else if (l_ok && l_type == EV_ON) begin
            dropped <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_voice_allocator.sv
// Directed bench for poly_voice_allocator: each task drives one scenario and checks inline.
module tb_poly_voice_allocator;
  import synth_voice_pkg::*;

  localparam int VOICES = 16;
  localparam int V_WIDTH = 4;
  localparam int CHANNELS = 4;
  localparam int C_WIDTH = 2;
  localparam int EV_CYCLES = VOICES + 1;

  logic reg_clk = 1'b0;
  logic reset_reg_N = 1'b0;
  logic steal_en = 1'b0;
  logic [VOICES-1:0] voice_free = '1;
  logic [VOICES-1:0] keys_on;
  logic note_on, note_stolen, dropped;
  logic [V_WIDTH-1:0] cur_key_adr;
  logic [7:0] cur_key_val, cur_vel_on, cur_vel_off;
  logic [C_WIDTH-1:0] cur_ch;
  logic [V_WIDTH:0] active_keys;

  int checks = 0;
  int errors = 0;
  int n_on, n_drop, n_steal;

  poly_voice_allocator_if #(.C_WIDTH(C_WIDTH)) bus ();

  poly_voice_allocator #(.VOICES(VOICES), .V_WIDTH(V_WIDTH), .CHANNELS(CHANNELS), .C_WIDTH(C_WIDTH)) dut (
    .reg_clk    (reg_clk),
    .reset_reg_N(reset_reg_N),
    .ev         (bus),
    .steal_en   (steal_en),
    .voice_free (voice_free),
    .keys_on    (keys_on),
    .note_on    (note_on),
    .cur_key_adr(cur_key_adr),
    .cur_key_val(cur_key_val),
    .cur_vel_on (cur_vel_on),
    .cur_vel_off(cur_vel_off),
    .cur_ch     (cur_ch),
    .note_stolen(note_stolen),
    .dropped    (dropped),
    .active_keys(active_keys)
  );

  always #5 reg_clk = ~reg_clk;

  task automatic do_reset();
    @(negedge reg_clk);
    reset_reg_N = 1'b0;
    steal_en = 1'b0;
    @(negedge reg_clk);
    reset_reg_N = 1'b1;
  endtask

  // Presents one event at a negedge; returns #1 after the accepting edge (cycle 1).
  task automatic send_ev(input ev_type_t t, input logic [C_WIDTH-1:0] ch, input logic [6:0] k, input logic [6:0] v);
    int n = 0;
    @(negedge reg_clk);
    while (bus.ev_ready !== 1'b1 && n < 50) begin
      @(negedge reg_clk);
      n++;
    end
    checks++;
    if (bus.ev_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_wait_ready got %b want 1", bus.ev_ready);
    end
    bus.ev_valid = 1'b1;
    bus.ev_type = t;
    bus.ev_ch = ch;
    bus.ev_key = k;
    bus.ev_val = v;
    @(posedge reg_clk);
    #1 bus.ev_valid = 1'b0;
    checks++;
    if (bus.ev_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready got %b want 0", bus.ev_ready);
    end
  endtask

  // Runs to cycle VOICES+2 counting strobes; sampled #1 after each edge.
  task automatic run_ev(output int on_cnt, output int drop_cnt, output int steal_cnt);
    on_cnt = 0;
    drop_cnt = 0;
    steal_cnt = 0;
    repeat (EV_CYCLES) begin
      @(posedge reg_clk);
      #1;
      if (note_on) on_cnt++;
      if (dropped) drop_cnt++;
      if (note_stolen) steal_cnt++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (keys_on !== '0 || active_keys !== '0) begin
      errors++;
      $display("FAIL reset_keys got %h/%0d want 0/0", keys_on, active_keys);
    end
    checks++;
    if (bus.ev_ready !== 1'b1 || note_on !== 1'b0 || dropped !== 1'b0 || cur_key_val !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b note_on=%b dropped=%b key=%0d want 1/0/0/0", bus.ev_ready, note_on, dropped, cur_key_val);
    end
  endtask

  task automatic test_note_on();
    do_reset();
    send_ev(EV_ON, 2'd0, 7'd60, 7'd100);
    repeat (EV_CYCLES - 1) @(posedge reg_clk);
    #1;
    checks++;
    if (note_on !== 1'b0 || bus.ev_ready !== 1'b0) begin
      errors++;
      $display("FAIL early_note_on cycle %0d note_on=%b ready=%b want 0/0", VOICES + 1, note_on, bus.ev_ready);
    end
    @(posedge reg_clk);
    #1;
    checks++;
    if (note_on !== 1'b1 || keys_on !== 16'h0001 || active_keys !== 5'd1) begin
      errors++;
      $display("FAIL note_on_gate note_on=%b keys=%h active=%0d want 1/0001/1", note_on, keys_on, active_keys);
    end
    checks++;
    if (cur_key_val !== 8'd60 || cur_vel_on !== 8'd100 || cur_key_adr !== 4'd0 || bus.ev_ready !== 1'b1) begin
      errors++;
      $display("FAIL note_on_cur key=%0d vel=%0d adr=%0d ready=%b want 60/100/0/1", cur_key_val, cur_vel_on, cur_key_adr, bus.ev_ready);
    end
  endtask

  task automatic test_fill_steal();
    do_reset();
    for (int i = 0; i < VOICES; i++) begin
      send_ev(EV_ON, 2'd0, 7'(40 + i), 7'd10);
      run_ev(n_on, n_drop, n_steal);
    end
    checks++;
    if (keys_on !== 16'hFFFF || active_keys !== 5'd16) begin
      errors++;
      $display("FAIL fill keys=%h active=%0d want ffff/16", keys_on, active_keys);
    end
    send_ev(EV_ON, 2'd0, 7'd70, 7'd10);
    run_ev(n_on, n_drop, n_steal);
    checks++;
    if (n_drop !== 1 || dropped !== 1'b1 || n_on !== 0 || keys_on !== 16'hFFFF) begin
      errors++;
      $display("FAIL drop drops=%0d dropped=%b strobes=%0d keys=%h want 1/1/0/ffff", n_drop, dropped, n_on, keys_on);
    end
    steal_en = 1'b1;
    send_ev(EV_ON, 2'd0, 7'd71, 7'd11);
    run_ev(n_on, n_drop, n_steal);
    checks++;
    if (note_stolen !== 1'b1 || note_on !== 1'b1 || cur_key_adr !== 4'd0 || cur_key_val !== 8'd71 || n_drop !== 0) begin
      errors++;
      $display("FAIL steal_oldest stolen=%b on=%b adr=%0d key=%0d drops=%0d want 1/1/0/71/0", note_stolen, note_on, cur_key_adr, cur_key_val, n_drop);
    end
    send_ev(EV_ON, 2'd0, 7'd72, 7'd12);
    run_ev(n_on, n_drop, n_steal);
    checks++;
    if (n_steal !== 1 || cur_key_adr !== 4'd1 || active_keys !== 5'd16) begin
      errors++;
      $display("FAIL steal_next steals=%0d adr=%0d active=%0d want 1/1/16", n_steal, cur_key_adr, active_keys);
    end
  endtask

  task automatic test_sustain();
    do_reset();
    send_ev(EV_SUS, 2'd1, 7'd0, 7'd127);
    run_ev(n_on, n_drop, n_steal);
    send_ev(EV_ON, 2'd1, 7'd64, 7'd90);
    run_ev(n_on, n_drop, n_steal);
    send_ev(EV_OFF, 2'd1, 7'd64, 7'd33);
    run_ev(n_on, n_drop, n_steal);
    checks++;
    if (n_on !== 0 || keys_on !== 16'h0001) begin
      errors++;
      $display("FAIL sus_hold strobes=%0d keys=%h want 0/0001", n_on, keys_on);
    end
    send_ev(EV_SUS, 2'd1, 7'd0, 7'd0);
    run_ev(n_on, n_drop, n_steal);
    checks++;
    if (n_on !== 1 || cur_key_val !== 8'd64 || cur_vel_off !== 8'd0 || keys_on !== '0 || active_keys !== 5'd0) begin
      errors++;
      $display("FAIL sus_release strobes=%0d key=%0d voff=%0d keys=%h active=%0d want 1/64/0/0000/0", n_on, cur_key_val, cur_vel_off, keys_on, active_keys);
    end
    send_ev(EV_ON, 2'd1, 7'd65, 7'd20);
    run_ev(n_on, n_drop, n_steal);
    send_ev(EV_OFF, 2'd1, 7'd65, 7'd33);
    run_ev(n_on, n_drop, n_steal);
    checks++;
    if (n_on !== 1 || cur_vel_off !== 8'd33 || cur_key_val !== 8'd65 || keys_on !== '0) begin
      errors++;
      $display("FAIL plain_off strobes=%0d voff=%0d key=%0d keys=%h want 1/33/65/0000", n_on, cur_vel_off, cur_key_val, keys_on);
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    send_ev(EV_ON, 2'd2, 7'd60, 7'd50);
    run_ev(n_on, n_drop, n_steal);
    send_ev(EV_ON, 2'd2, 7'd60, 7'd80);
    run_ev(n_on, n_drop, n_steal);
    checks++;
    if (cur_key_adr !== 4'd0 || cur_vel_on !== 8'd80 || active_keys !== 5'd1 || cur_ch !== 2'd2) begin
      errors++;
      $display("FAIL retrigger adr=%0d vel=%0d active=%0d ch=%0d want 0/80/1/2", cur_key_adr, cur_vel_on, active_keys, cur_ch);
    end
    send_ev(EV_ON, 2'd2, 7'd60, 7'd0);
    run_ev(n_on, n_drop, n_steal);
    checks++;
    if (n_on !== 1 || keys_on !== '0 || cur_vel_off !== 8'd0 || cur_vel_on !== 8'd0) begin
      errors++;
      $display("FAIL vel0_off strobes=%0d keys=%h voff=%0d von=%0d want 1/0000/0/0", n_on, keys_on, cur_vel_off, cur_vel_on);
    end
  endtask

  task automatic test_all_off();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_ev(EV_ON, 2'd3, 7'(60 + i), 7'd40);
      run_ev(n_on, n_drop, n_steal);
    end
    send_ev(EV_ON, 2'd0, 7'd50, 7'd40);
    run_ev(n_on, n_drop, n_steal);
    send_ev(EV_ALLOFF, 2'd3, 7'd0, 7'd0);
    run_ev(n_on, n_drop, n_steal);
    checks++;
    if (n_on !== 4 || keys_on !== 16'h0010 || active_keys !== 5'd1) begin
      errors++;
      $display("FAIL all_off strobes=%0d keys=%h active=%0d want 4/0010/1", n_on, keys_on, active_keys);
    end
  endtask

  task automatic test_reset_mid_scan();
    send_ev(EV_ON, 2'd0, 7'd90, 7'd70);
    repeat (5) @(posedge reg_clk);
    @(negedge reg_clk);
    reset_reg_N = 1'b0;
    #1;
    checks++;
    if (keys_on !== '0 || active_keys !== '0 || cur_key_val !== 8'd0 || bus.ev_ready !== 1'b1 || note_on !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset keys=%h active=%0d key=%0d ready=%b on=%b want 0000/0/0/1/0", keys_on, active_keys, cur_key_val, bus.ev_ready, note_on);
    end
    @(negedge reg_clk);
    reset_reg_N = 1'b1;
    send_ev(EV_ON, 2'd0, 7'd91, 7'd71);
    run_ev(n_on, n_drop, n_steal);
    checks++;
    if (n_on !== 1 || keys_on !== 16'h0001 || cur_key_val !== 8'd91) begin
      errors++;
      $display("FAIL post_reset strobes=%0d keys=%h key=%0d want 1/0001/91", n_on, keys_on, cur_key_val);
    end
  endtask

  initial begin
    bus.ev_valid = 1'b0;
    bus.ev_type = EV_OFF;
    bus.ev_ch = '0;
    bus.ev_key = '0;
    bus.ev_val = '0;
    test_reset();
    test_note_on();
    test_fill_steal();
    test_sustain();
    test_retrigger();
    test_all_off();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly_voice_allocator.md
# poly_voice_allocator

Multi-channel polyphonic voice allocator: the parametrised successor of the single-channel note stack inside the synth controller. It accepts decoded note, sustain and all-notes-off events from up to CHANNELS MIDI channels and maps them onto VOICES synth voices. It adds per-channel sustain pedal handling, same-key retrigger and optional oldest-voice stealing. It sits between the MIDI status/sequencer decode and the synth engine, and drives the same keys_on and note-event bus the engine already consumes.

## Interface
- VOICES, 16, number of synth voices.
- V_WIDTH, 4, clog2(VOICES).
- CHANNELS, 4, number of MIDI channels tracked (1..16).
- C_WIDTH, 2, clog2(CHANNELS), minimum 1.
- reg_clk  in  1  single clock; all logic is rising-edge.
- reset_reg_N  in  1  asynchronous, active-low reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  allocator idle; an event is accepted when ev_valid && ev_ready.
- ev_type  in  2  0 = note-off, 1 = note-on, 2 = sustain CC64, 3 = all-notes-off.
- ev_ch  in  C_WIDTH  event channel.
- ev_key  in  7  key number.
- ev_val  in  7  velocity or CC value.
- steal_en  in  1  enables stealing of the oldest voice when no voice is available.
- voice_free  in  VOICES  engine flag per voice: envelope finished.
- keys_on  out  VOICES  gate per voice.
- note_on  out  1  one-cycle strobe marking a voice update on cur_*.
- cur_key_adr  out  V_WIDTH  voice being updated.
- cur_key_val  out  8  {0, key}.
- cur_vel_on  out  8  {0, velocity} for note-on updates.
- cur_vel_off  out  8  {0, release velocity} for releases; 0 for sustain and all-off releases.
- cur_ch  out  C_WIDTH  channel of the update.
- note_stolen  out  1  strobe coincident with note_on when the voice was stolen.
- dropped  out  1  one-cycle strobe when a note-on finds no voice.
- active_keys  out  V_WIDTH+1  popcount of keys_on.

## Operation
- Per-voice state: key[7], ch, held, age[8]. Per-channel state: sus bit.
- A voice is available when keys_on=0, held=0 and voice_free=1.
- A note-on with velocity 0 is treated as a note-off with release velocity 0.
- FSM states:
  - IDLE (ev_ready=1): on accept, latch the event and go to SCAN.
  - SCAN: visits voice index 0..VOICES-1, one voice per cycle.
  - COMMIT: 1 cycle, then back to IDLE.
- Note-on voice selection, in priority order:
  1. A voice with keys_on=1, matching ch and key (retrigger).
  2. The lowest-index available voice.
  3. If steal_en, the voice with maximum age; ties go to the lowest index.
  4. Otherwise no voice: dropped pulses and no state changes.
- Note-on commit effects:
  - Selected voice: keys_on=1, held=0, age=0, key and ch loaded.
  - Every other voice with keys_on=1: age increments, saturating at 255.
- Note-off (SCAN): the first voice with keys_on=1, held=0 and matching ch/key is released.
  - If sus[ch]=0: keys_on cleared and a strobe is issued.
  - If sus[ch]=1: held is set and no strobe is issued.
  - No match: no effect.
- Sustain event:
  - ev_val ≥ 64 sets sus[ch] and produces no scan effects.
  - ev_val < 64 clears sus[ch]. Every voice of that channel with held=1 gets held=0, keys_on=0 and a strobe.
- All-notes-off: every voice of the channel with keys_on=1 is released with a strobe, regardless of sus. sus[ch] is cleared.
- An event with ev_ch ≥ CHANNELS is accepted and ignored.
- voice_free is sampled when the voice is visited. Changes after that visit do not affect the current event.

## Timing
- Reset: state IDLE; ev_ready=1; keys_on, held, sus, age, key, ch = 0; all strobes 0; cur_* = 0; active_keys = 0.
- Reset asserted mid-scan aborts the event; the event is lost.
- Event accepted in cycle 0 → SCAN in cycles 1..VOICES → COMMIT in cycle VOICES+1 → ev_ready=1 in cycle VOICES+2.
- Note-on: note_on, note_stolen or dropped, keys_on, cur_* and active_keys all become visible in cycle VOICES+2.
- Releases: the update for voice i is visible in cycle i+2. Strobes are one cycle each.
- active_keys always tracks keys_on in the same cycle.
- ev_ready=0 from cycle 1 through VOICES+1. ev_valid held during that window is not accepted.

## Structure
- Shared package synth_voice_pkg holds:
  - ev_type_t enum (EV_OFF, EV_ON, EV_SUS, EV_ALLOFF);
  - alloc_state_t (IDLE, SCAN, COMMIT);
  - SUSTAIN_THRESH = 64;
  - AGE_W = 8, AGE_MAX = 255.
- Sub-module voice_slot, one per voice via generate. It holds key, ch, held and age, and exposes match/available/age compare inputs to the top.
- Top level holds the FSM, the scan index, the best-candidate registers and the sus vector.

## Test plan
- Reset, then note-on ch0 key60 vel100 → in cycle VOICES+2: voice 0 keys_on, cur_key_val=60, cur_vel_on=100, active_keys=1.
- Fill all 16 voices, steal_en=0, then a 17th note-on → dropped=1 and keys_on unchanged. Repeat with steal_en=1 → voice 0 reused, note_stolen=1.
- Sustain ch1 val=127, note-on/off key64 → keys_on stays 1 with no strobe. Then sustain val=0 → strobe with cur_key_val=64 and keys_on cleared.
- Note-on key60 twice on ch2 → same voice retriggered, active_keys=1. Then note-on key60 vel0 → released.
- Four notes on ch3 plus one on ch0, then all-notes-off ch3 → exactly 4 strobes, and the ch0 voice remains on.
- Assert reset_reg_N low mid-SCAN → all outputs return to reset values immediately and ev_ready=1 after release.
